// File: rtl/prog_loader_pkg.sv
// Shared constants for the boot-time program loader: frame magic bytes,
// error codes and FSM state encodings.
package prog_loader_pkg;

  localparam logic [7:0] LDR_MAGIC0 = 8'hA5;
  localparam logic [7:0] LDR_MAGIC1 = 8'h5A;

  localparam logic [1:0] LDR_ERR_NONE  = 2'd0;
  localparam logic [1:0] LDR_ERR_MAGIC = 2'd1;
  localparam logic [1:0] LDR_ERR_LEN   = 2'd2;
  localparam logic [1:0] LDR_ERR_CSUM  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MAGIC1 = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: parses a framed byte stream (A5 5A LEN32 payload CSUM), writes the
// payload to memory and releases the CPU reset once the checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 4096,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Handshake: a byte transfers on a rising edge where s_valid_i & s_ready_o;
  // s_valid_i may drop at any time, s_ready_o falls only once the CPU is released.
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              cpu_rstn_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  localparam int CNT_W = $clog2(MEM_BYTES + 1);

  ldr_state_e        state_q;
  logic [31:0]       len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        csum_q;
  logic [1:0]        idx_q;

  logic              accept;
  logic [31:0]       len_d;
  logic [7:0]        csum_d;
  logic [ADDR_W-1:0] addr_d;
  logic              last_byte;

  assign s_ready_o = (state_q != ST_RUN);
  assign accept    = s_valid_i & s_ready_o;
  // Length arrives little-endian, so each new byte enters at the top.
  assign len_d     = {s_data_i, len_q[31:8]};
  assign csum_d    = csum_q + s_data_i;
  assign addr_d    = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);
  assign last_byte = (32'(cnt_q) == (len_q - 32'd1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_rstn_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= LDR_ERR_NONE;
    end else begin
      mem_we_o <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (s_data_i == LDR_MAGIC0) begin
              state_q    <= ST_MAGIC1;
              err_o      <= 1'b0;
              err_code_o <= LDR_ERR_NONE;
            end
          end
          ST_MAGIC1: begin
            if (s_data_i == LDR_MAGIC1) begin
              state_q <= ST_LEN;
              idx_q   <= '0;
            end else begin
              state_q    <= ST_IDLE;
              err_o      <= 1'b1;
              err_code_o <= LDR_ERR_MAGIC;
            end
          end
          ST_LEN: begin
            len_q <= len_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              cnt_q  <= '0;
              csum_q <= '0;
              if (len_d > 32'(MEM_BYTES)) begin
                state_q    <= ST_IDLE;
                err_o      <= 1'b1;
                err_code_o <= LDR_ERR_LEN;
              end else if (len_d == 32'd0) begin
                state_q <= ST_CSUM;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= s_data_i;
            csum_q      <= csum_d;
            cnt_q       <= cnt_q + CNT_W'(1);
            if (last_byte) state_q <= ST_CSUM;
          end
          ST_CSUM: begin
            if (s_data_i == csum_q) begin
              state_q    <= ST_RUN;
              done_o     <= 1'b1;
              cpu_rstn_o <= 1'b1;
            end else begin
              state_q    <= ST_IDLE;
              err_o      <= 1'b1;
              err_code_o <= LDR_ERR_CSUM;
            end
          end
          ST_RUN:  ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drivers push expected memory writes into a
// queue that a negedge monitor pops and compares; status checks run inline.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W    = 12;
  localparam int MEM_BYTES = 4096;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              s_valid_i = 1'b0;
  logic [7:0]        s_data_i = 8'h00;
  logic              s_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic              cpu_rstn_o;
  logic              done_o;
  logic              err_o;
  logic [1:0]        err_code_o;

  int compared   = 0;
  int mismatched = 0;
  logic [ADDR_W+7:0] exp_q[$];

  prog_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .cpu_rstn_o(cpu_rstn_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected (addr, data).
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && mem_we_o) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: actual addr 0x%0h data 0x%0h required no write",
                   mem_addr_o, mem_wdata_o);
        end else begin
          check("mem_write", {mem_addr_o, mem_wdata_o}, 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called #1 after a rising edge; returns #1 after the edge that accepted b.
  task automatic send_byte(input logic [7:0] b, input bit payload,
                           input logic [ADDR_W-1:0] addr, input bit gap);
    bit rdy;
    int budget;
    budget = 0;
    s_valid_i = 1'b1;
    s_data_i  = b;
    if (payload) exp_q.push_back({addr, b});
    do begin
      rdy = s_ready_o;
      @(posedge clk_i);
      #1;
      budget++;
    end while (!rdy && budget < 50);
    if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
    if (payload) check("we_after_accept", 32'(mem_we_o), 32'd1);
    s_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk_i);
      #1;
      check("we_gap", 32'(mem_we_o), 32'd0);
    end
  endtask

  task automatic send_good_frame(input logic [7:0] pl[$], input bit gap);
    logic [31:0] len;
    logic [7:0]  csum;
    len  = 32'(pl.size());
    csum = 8'h00;
    send_byte(8'hA5, 1'b0, '0, gap);
    check("err_clear_on_a5", {30'd0, err_o, 1'b0} | 32'(err_code_o), 32'd0);
    send_byte(8'h5A, 1'b0, '0, gap);
    send_byte(len[7:0], 1'b0, '0, gap);
    send_byte(len[15:8], 1'b0, '0, gap);
    send_byte(len[23:16], 1'b0, '0, gap);
    send_byte(len[31:24], 1'b0, '0, gap);
    for (int i = 0; i < pl.size(); i++) begin
      send_byte(pl[i], 1'b1, ADDR_W'(i), gap);
      csum = csum + pl[i];
    end
    check("done_before_csum", 32'(done_o), 32'd0);
    send_byte(csum, 1'b0, '0, gap);
    check("done", 32'(done_o), 32'd1);
    check("cpu_rstn", 32'(cpu_rstn_o), 32'd1);
    check("ready_run", 32'(s_ready_o), 32'd0);
    check("err_run", 32'(err_o), 32'd0);
  endtask

  task automatic send_raw(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b0, '0, 1'b0);
  endtask

  task automatic check_error(input string name, input logic [1:0] code);
    check({name, "_err"}, 32'(err_o), 32'd1);
    check({name, "_code"}, 32'(err_code_o), 32'(code));
    check({name, "_rstn"}, 32'(cpu_rstn_o), 32'd0);
    check({name, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ready"}, 32'(s_ready_o), 32'd1);
    check({name, "_we"}, 32'(mem_we_o), 32'd0);
    check({name, "_addr"}, 32'(mem_addr_o), 32'd0);
    check({name, "_wdata"}, 32'(mem_wdata_o), 32'd0);
    check({name, "_rstn"}, 32'(cpu_rstn_o), 32'd0);
    check({name, "_done"}, 32'(done_o), 32'd0);
    check({name, "_err"}, {30'd0, err_o, 1'b0} | 32'(err_code_o), 32'd0);
  endtask

  task automatic do_reset();
    #1 rst_i = 1'b1;
    #2;
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] nominal[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] empty_pl[$];
  logic [7:0] one_pl[$] = '{8'h7E};

  initial begin
    #12;
    check_reset_values("reset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Nominal continuous load; payload sum 0x11+0x22+0x33+0x44 = 0xAA.
    send_good_frame(nominal, 1'b0);
    s_valid_i = 1'b1;
    s_data_i  = 8'hA5;
    repeat (3) @(posedge clk_i);
    #1 s_valid_i = 1'b0;
    check("run_hold_done", 32'(done_o), 32'd1);
    check("run_hold_state", 32'(dut.state_q), 32'(ST_RUN));
    do_reset();

    // Same frame with valid toggling every cycle.
    send_good_frame(nominal, 1'b1);
    do_reset();

    // Checksum error: payload still written, then a good frame recovers.
    send_raw('{8'hA5, 8'h5A, 8'h04, 8'h00, 8'h00, 8'h00});
    foreach (nominal[i]) send_byte(nominal[i], 1'b1, ADDR_W'(i), 1'b0);
    send_byte(8'h00, 1'b0, '0, 1'b0);
    check_error("csum", LDR_ERR_CSUM);
    send_good_frame(nominal, 1'b0);
    do_reset();

    // Length limit: 4097 rejected with no writes; zero length succeeds.
    send_raw('{8'hA5, 8'h5A, 8'h01, 8'h10, 8'h00, 8'h00});
    check_error("len", LDR_ERR_LEN);
    send_good_frame(empty_pl, 1'b0);
    do_reset();

    // Hunt and bad second magic; the bad byte is consumed, not re-hunted.
    send_raw('{8'h00, 8'hFF});
    check("hunt_err", 32'(err_o), 32'd0);
    check("hunt_state", 32'(dut.state_q), 32'(ST_IDLE));
    send_raw('{8'hA5, 8'h12});
    check_error("magic", LDR_ERR_MAGIC);
    send_good_frame(one_pl, 1'b0);
    do_reset();

    // Reset after the 2nd payload byte, with its write strobe in flight.
    send_raw('{8'hA5, 8'h5A, 8'h04, 8'h00, 8'h00, 8'h00});
    send_byte(8'h11, 1'b1, 12'd0, 1'b0);
    send_byte(8'h22, 1'b1, 12'd1, 1'b0);
    #1 rst_i = 1'b1;
    #1;
    check_reset_values("midreset");
    check("midreset_state", 32'(dut.state_q), 32'(ST_IDLE));
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    send_good_frame(nominal, 1'b0);

    repeat (3) @(posedge clk_i);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
